// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the execute-stage divider.
//   - DivFree/DivByZero/DivOn/DivEnd : divider FSM state encodings (2 bits)
//   - DivResultReady/NotReady        : values driven on ready_o
//   - DivStart/DivStop               : values seen on start_i
//   - ZeroWord/DoubleZeroWord        : zero operand / zero result constants
package div_unit_pkg;

  localparam int DivDataW = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [DivDataW-1:0]   ZeroWord       = 32'h0000_0000;
  localparam logic [2*DivDataW-1:0] DoubleZeroWord = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit is produced per clock; the result is held until EX drops
// start_i.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU (sampled with start_i)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until the result is consumed
//   annul_i       cancel an in-flight division
//   result_o      {remainder, quotient}
//   ready_o       result valid
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DivDataW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int RES_W  = 2 * DATA_W;
  localparam int WORK_W = 2 * DATA_W + 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  localparam logic [DATA_W-1:0] OneWord  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CntZero  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(DATA_W);

  // Two's-complement negate, used for magnitudes and for sign correction.
  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return ~v + OneWord;
  endfunction

  div_state_t          state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  // {partial remainder (DATA_W+1 bits), dividend / quotient (DATA_W bits)}
  logic [WORK_W-1:0]   work_r, work_s;
  logic [DATA_W-1:0]   divisor_r, divisor_s;
  logic                qsign_r, qsign_s;
  logic                rsign_r, rsign_s;
  logic [RES_W-1:0]    result_r, result_s;
  logic                ready_r, ready_s;

  logic [WORK_W-1:0]   shifted_s;
  logic [DATA_W:0]     trial_s;
  logic [WORK_W-1:0]   step_s;
  logic                sign1_s, sign2_s;
  logic [DATA_W-1:0]   mag1_s, mag2_s;
  logic [DATA_W-1:0]   quot_s, rem_s;

  // One restoring iteration: shift, trial-subtract, keep or restore.
  always_comb begin
    shifted_s = work_r << 1;
    trial_s   = shifted_s[WORK_W-1:DATA_W] - {1'b0, divisor_r};
    // The shifted remainder is below 2*divisor, so the MSB of the
    // difference is a reliable sign bit.
    if (trial_s[DATA_W] == 1'b0) begin
      step_s = {trial_s, shifted_s[DATA_W-1:1], 1'b1};
    end else begin
      step_s = shifted_s;
    end
  end

  // Operand magnitudes and sign flags for the signed path.
  always_comb begin
    sign1_s = signed_div_i & opdata1_i[DATA_W-1];
    sign2_s = signed_div_i & opdata2_i[DATA_W-1];
    if (sign1_s) begin
      mag1_s = twos_neg(opdata1_i);
    end else begin
      mag1_s = opdata1_i;
    end
    if (sign2_s) begin
      mag2_s = twos_neg(opdata2_i);
    end else begin
      mag2_s = opdata2_i;
    end
  end

  // Sign correction of the finished unsigned quotient and remainder.
  always_comb begin
    if (qsign_r) begin
      quot_s = twos_neg(work_r[DATA_W-1:0]);
    end else begin
      quot_s = work_r[DATA_W-1:0];
    end
    if (rsign_r) begin
      rem_s = twos_neg(work_r[RES_W-1:DATA_W]);
    end else begin
      rem_s = work_r[RES_W-1:DATA_W];
    end
  end

  // Next-state and output logic of the divider FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    work_s    = work_r;
    divisor_s = divisor_r;
    qsign_s   = qsign_r;
    rsign_s   = rsign_r;
    result_s  = result_r;
    ready_s   = ready_r;
    case (state_r)
      DivFree: begin
        ready_s  = DivResultNotReady;
        result_s = RES_W'(DoubleZeroWord);
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == DATA_W'(ZeroWord)) begin
            state_s = DivByZero;
          end else begin
            state_s   = DivOn;
            cnt_s     = CntZero;
            work_s    = {{(DATA_W+1){1'b0}}, mag1_s};
            divisor_s = mag2_s;
            qsign_s   = sign1_s ^ sign2_s;
            rsign_s   = sign1_s;
          end
        end else begin
          state_s = DivFree;
        end
      end
      DivByZero: begin
        state_s  = DivEnd;
        result_s = RES_W'(DoubleZeroWord);
        ready_s  = DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          state_s  = DivFree;
          cnt_s    = CntZero;
          ready_s  = DivResultNotReady;
          result_s = RES_W'(DoubleZeroWord);
        end else if (cnt_r != CntLast) begin
          work_s = step_s;
          cnt_s  = cnt_r + CntOne;
        end else begin
          state_s  = DivEnd;
          cnt_s    = CntZero;
          result_s = {rem_s, quot_s};
          ready_s  = DivResultReady;
        end
      end
      DivEnd: begin
        // annul_i is deliberately ignored: the result is already complete.
        if (start_i == DivStop) begin
          state_s  = DivFree;
          ready_s  = DivResultNotReady;
          result_s = RES_W'(DoubleZeroWord);
        end else begin
          state_s = DivEnd;
        end
      end
      default: begin
        state_s  = DivFree;
        cnt_s    = CntZero;
        ready_s  = DivResultNotReady;
        result_s = RES_W'(DoubleZeroWord);
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= DivFree;
      cnt_r     <= CntZero;
      work_r    <= {WORK_W{1'b0}};
      divisor_r <= DATA_W'(ZeroWord);
      qsign_r   <= 1'b0;
      rsign_r   <= 1'b0;
      result_r  <= RES_W'(DoubleZeroWord);
      ready_r   <= DivResultNotReady;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      work_r    <= work_s;
      divisor_r <= divisor_s;
      qsign_r   <= qsign_s;
      rsign_r   <= rsign_s;
      result_r  <= result_s;
      ready_r   <= ready_s;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized scoreboard bench for div_unit.
// A driver issues divisions and queues the expected {remainder, quotient}
// and latency; a monitor compares every cycle the DUT presents.
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div;
  logic [W-1:0]   op1, op2;
  logic           start, annul;
  logic [2*W-1:0] result;
  logic           ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  div_unit #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'h0, a});
      y = longint'({32'h0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: pops on each rising ready, checks hold and idle-zero otherwise.
  initial begin
    exp_t cur;
    bit   prev;
    prev = 1'b0;
    cur  = '{64'h0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (ready && !prev) begin
          if (sb_q.size() == 0) begin
            check("spurious_ready", {63'h0, ready}, 64'h0);
          end else begin
            cur = sb_q.pop_front();
            check("result", result, cur.res);
            check("latency", 64'(cyc - cur.issue), 64'(cur.lat));
          end
        end else if (ready) begin
          check("result_hold", result, cur.res);
        end else begin
          check("idle_result_zero", result, 64'h0);
        end
        prev = ready;
      end
    end
  end

  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    e.res   = ref_div(s, a, b);
    e.issue = cyc;
    e.lat   = (b == 32'h0) ? 2 : 34;
    sb_q.push_back(e);
    // Operands are scrambled after being sampled; only latched copies count.
    @(posedge clk); #1;
    op1        = $urandom;
    op2        = $urandom;
    signed_div = 1'($urandom_range(0, 1));
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    check("ready_timeout", {63'h0, ready}, 64'h1);
    // Hold one extra edge with start high, then release.
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_ready", {63'h0, ready}, 64'h0);
    check("drop_result", result, 64'h0);
  endtask

  initial begin
    logic [31:0] a, b;
    bit          s;
    int          pick;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    op1 = 32'h0; op2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'h0, ready}, 64'h0);
    check("reset_result", result, 64'h0);
    rst = 1'b0;

    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_op(1'b0, 32'h1234_5678, 32'h0);
    do_op(1'b1, 32'h1234_5678, 32'h0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'd5, 32'd9);

    // Annul ten iterations into an operation; no result may appear.
    @(posedge clk); #1;
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    repeat (40) @(posedge clk);
    do_op(1'b0, 32'd20, 32'd3);

    // Reset in the middle of the iterations.
    @(posedge clk); #1;
    signed_div = 1'b0; op1 = 32'd123456789; op2 = 32'd1234; start = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("midreset_ready", {63'h0, ready}, 64'h0);
    check("midreset_result", result, 64'h0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    do_op(1'b0, 32'd9, 32'd3);

    for (int n = 0; n < 24; n++) begin
      s    = 1'($urandom_range(0, 1));
      a    = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) begin
        b = 32'h0;
      end else if (pick < 4) begin
        b = 32'($urandom_range(1, 15));
        if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
      end else begin
        b = $urandom;
      end
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 100));
      do_op(s, a, b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
